// File: rtl/dt_thresh.sv
// dt_thresh
// Scans a distance map (IMG_PIX pixels, 8 bits each, row-major) once per start
// request. Every pixel is compared with a threshold latched at start, and the
// resulting mask bits are packed WORD_PIX per word, leftmost pixel in the MSB.
// Along the way the block tracks the largest distance, the lowest address that
// holds it, and the count of nonzero pixels.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   start     single-cycle scan request (ignored while busy)
//   thr       threshold, latched when start is accepted
//   res_rd    distance-map read strobe
//   res_addr  distance-map pixel address
//   res_di    distance-map read data, valid one cycle after its address
//   out_wr    packed-mask write strobe
//   out_addr  packed-mask word address
//   out_do    packed-mask write data
//   busy      scan in progress
//   done      results valid (level, held until the next accepted start)
//   max_val   largest distance seen
//   max_addr  lowest address holding max_val
//   fg_cnt    number of nonzero pixels
module dt_thresh #(
    parameter int IMG_PIX  = 16384,
    parameter int WORD_PIX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  thr,
    output logic        res_rd,
    output logic [13:0] res_addr,
    input  logic [7:0]  res_di,
    output logic        out_wr,
    output logic [9:0]  out_addr,
    output logic [15:0] out_do,
    output logic        busy,
    output logic        done,
    output logic [7:0]  max_val,
    output logic [13:0] max_addr,
    output logic [14:0] fg_cnt
);

    localparam logic [13:0] LAST_PIX  = 14'(IMG_PIX - 1);
    localparam logic [9:0]  LAST_WORD = 10'(IMG_PIX / WORD_PIX - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(WORD_PIX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q,    state_d;
    logic        rdEn_q,     rdEn_d;
    logic [13:0] rdAddr_q,   rdAddr_d;
    logic        capValid_q, capValid_d;
    logic [13:0] capAddr_q,  capAddr_d;
    logic [7:0]  thr_q,      thr_d;
    logic [15:0] pack_q,     pack_d;
    logic        outWr_q,    outWr_d;
    logic [9:0]  outAddr_q,  outAddr_d;
    logic [15:0] outData_q,  outData_d;
    logic [7:0]  maxVal_q,   maxVal_d;
    logic [13:0] maxAddr_q,  maxAddr_d;
    logic [14:0] fgCnt_q,    fgCnt_d;

    logic        maskBit;
    logic [15:0] packNext;

    // Mask bit of the pixel arriving this cycle, shifted in at the LSB so the
    // first pixel of a word ends up in the MSB after a full word of shifts.
    assign maskBit  = (res_di >= thr_q);
    assign packNext = {pack_q[14:0], maskBit};

    // Next-state and datapath logic. The capture stage runs one cycle behind
    // the address stage (capValid_q/capAddr_q), matching the read latency.
    // A write is issued the cycle after the last pixel of a word is captured,
    // and the scan finishes once the final word has gone out.
    always_comb begin
        state_d    = state_q;
        rdEn_d     = rdEn_q;
        rdAddr_d   = rdAddr_q;
        capValid_d = rdEn_q;
        capAddr_d  = rdAddr_q;
        thr_d      = thr_q;
        pack_d     = pack_q;
        outWr_d    = 1'b0;
        outAddr_d  = outAddr_q;
        outData_d  = outData_q;
        maxVal_d   = maxVal_q;
        maxAddr_d  = maxAddr_q;
        fgCnt_d    = fgCnt_q;

        if (capValid_q) begin
            pack_d = packNext;
            // Strictly greater keeps the lowest address on ties.
            if (res_di > maxVal_q) begin
                maxVal_d  = res_di;
                maxAddr_d = capAddr_q;
            end
            if (res_di != 8'd0) begin
                fgCnt_d = fgCnt_q + 15'd1;
            end
            if (capAddr_q[3:0] == LAST_BIT) begin
                outWr_d   = 1'b1;
                outAddr_d = capAddr_q[13:4];
                outData_d = packNext;
            end
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = READ;
                    rdEn_d    = 1'b1;
                    rdAddr_d  = 14'd0;
                    thr_d     = thr;
                    pack_d    = 16'd0;
                    maxVal_d  = 8'd0;
                    maxAddr_d = 14'd0;
                    fgCnt_d   = 15'd0;
                end
            end
            READ: begin
                if (rdAddr_q == LAST_PIX) begin
                    rdEn_d  = 1'b0;
                    state_d = DRAIN;
                end else begin
                    rdAddr_d = rdAddr_q + 14'd1;
                end
            end
            DRAIN: begin
                if (outWr_q && (outAddr_q == LAST_WORD)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything so every output
    // reads zero while reset is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rdEn_q     <= 1'b0;
            rdAddr_q   <= 14'd0;
            capValid_q <= 1'b0;
            capAddr_q  <= 14'd0;
            thr_q      <= 8'd0;
            pack_q     <= 16'd0;
            outWr_q    <= 1'b0;
            outAddr_q  <= 10'd0;
            outData_q  <= 16'd0;
            maxVal_q   <= 8'd0;
            maxAddr_q  <= 14'd0;
            fgCnt_q    <= 15'd0;
        end else begin
            state_q    <= state_d;
            rdEn_q     <= rdEn_d;
            rdAddr_q   <= rdAddr_d;
            capValid_q <= capValid_d;
            capAddr_q  <= capAddr_d;
            thr_q      <= thr_d;
            pack_q     <= pack_d;
            outWr_q    <= outWr_d;
            outAddr_q  <= outAddr_d;
            outData_q  <= outData_d;
            maxVal_q   <= maxVal_d;
            maxAddr_q  <= maxAddr_d;
            fgCnt_q    <= fgCnt_d;
        end
    end

    assign res_rd   = rdEn_q;
    assign res_addr = rdAddr_q;
    assign out_wr   = outWr_q;
    assign out_addr = outAddr_q;
    assign out_do   = outData_q;
    assign busy     = (state_q == READ) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign max_val  = maxVal_q;
    assign max_addr = maxAddr_q;
    assign fg_cnt   = fgCnt_q;

endmodule

// File: tb/tb_dt_thresh.sv
// tb_dt_thresh
// Drives dt_thresh through several scans against a behavioural distance-map
// memory. Expected mask words are queued when a scan is issued and compared
// by an independent write monitor; scan results and timing are compared at
// the end of each scan.
module tb_dt_thresh;

    localparam int NPIX  = 16384;
    localparam int NWORD = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  thr = 8'd0;
    logic        res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di = 8'd0;
    logic        out_wr;
    logic [9:0]  out_addr;
    logic [15:0] out_do;
    logic        busy;
    logic        done;
    logic [7:0]  max_val;
    logic [13:0] max_addr;
    logic [14:0] fg_cnt;

    dt_thresh #(.IMG_PIX(NPIX), .WORD_PIX(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .thr      (thr),
        .res_rd   (res_rd),
        .res_addr (res_addr),
        .res_di   (res_di),
        .out_wr   (out_wr),
        .out_addr (out_addr),
        .out_do   (out_do),
        .busy     (busy),
        .done     (done),
        .max_val  (max_val),
        .max_addr (max_addr),
        .fg_cnt   (fg_cnt)
    );

    always #5 clk = ~clk;

    // Distance-map memory with one cycle of read latency.
    logic [7:0] mem [NPIX];

    always @(posedge clk) begin
        if (res_rd) res_di <= mem[res_addr];
    end

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t expQ[$];
    wr_t popE;
    int  checks = 0;
    int  errors = 0;
    int  wrCount = 0;
    int  rdCount = 0;
    int  rdErrs = 0;
    logic [13:0] rdNext = 14'd0;
    int  expMax, expMaxAddr, expFg;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: mask words and statistics straight from the map.
    task automatic buildExpected(input int t);
        wr_t e;
        expQ.delete();
        expMax = 0;
        expMaxAddr = 0;
        expFg = 0;
        for (int w = 0; w < NWORD; w++) begin
            e.addr = 10'(w);
            e.data = 16'd0;
            for (int b = 0; b < 16; b++) begin
                if (int'(mem[w * 16 + b]) >= t) e.data[15 - b] = 1'b1;
            end
            expQ.push_back(e);
        end
        for (int i = 0; i < NPIX; i++) begin
            if (int'(mem[i]) > expMax) begin
                expMax = int'(mem[i]);
                expMaxAddr = i;
            end
            if (mem[i] != 8'd0) expFg++;
        end
    endtask

    // Write monitor pops the scoreboard; read monitor tracks the address run.
    always @(negedge clk) begin
        if (out_wr) begin
            wrCount++;
            if (expQ.size() == 0) begin
                checkOutput("spurious_write_addr", {22'd0, out_addr}, 32'hFFFF_FFFF);
            end else begin
                popE = expQ.pop_front();
                checkOutput("wr_addr", {22'd0, out_addr}, {22'd0, popE.addr});
                checkOutput("wr_data", {16'd0, out_do}, {16'd0, popE.data});
            end
        end
        if (res_rd) begin
            if (res_addr !== rdNext) rdErrs++;
            rdNext = res_addr + 14'd1;
            rdCount++;
        end
    end

    function automatic logic anyOutput();
        return |{res_rd, res_addr, out_wr, out_addr, out_do, busy, done, max_val, max_addr, fg_cnt};
    endfunction

    // One scan: latch t, optionally re-pulse start or assert reset mid-scan.
    task automatic applyStimulus(input logic [7:0] t, input int restartAt, input int resetAt);
        int n;
        int wrBefore;
        bit aborted;
        buildExpected(int'(t));
        wrCount = 0;
        rdCount = 0;
        rdErrs = 0;
        rdNext = 14'd0;
        aborted = 1'b0;
        @(negedge clk);
        thr = t;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        thr = 8'($urandom);
        n = 1;
        checkOutput("cycle1_rd_busy_done", {29'd0, res_rd, busy, done}, 32'd6);
        checkOutput("cycle1_addr", {18'd0, res_addr}, 32'd0);
        while (!done && n < 20000 && !aborted) begin
            @(negedge clk);
            n++;
            if (n == restartAt) begin
                start = 1'b1;
                thr = ~t;
            end else begin
                start = 1'b0;
            end
            if (n == resetAt) begin
                reset = 1'b1;
                @(negedge clk);
                n++;
                checkOutput("reset_outputs_zero", {31'd0, anyOutput()}, 32'd0);
                reset = 1'b0;
                aborted = 1'b1;
            end
        end
        if (aborted) begin
            expQ.delete();
            wrBefore = wrCount;
            repeat (40) @(negedge clk);
            checkOutput("no_write_after_reset", wrCount, wrBefore);
            checkOutput("idle_after_reset", {31'd0, anyOutput()}, 32'd0);
        end else begin
            checkOutput("done_cycle", n, 16387);
            checkOutput("write_count", wrCount, NWORD);
            checkOutput("queue_empty", expQ.size(), 0);
            checkOutput("read_count", rdCount, NPIX);
            checkOutput("read_sequence_errs", rdErrs, 0);
            checkOutput("max_val", {24'd0, max_val}, expMax);
            checkOutput("max_addr", {18'd0, max_addr}, expMaxAddr);
            checkOutput("fg_cnt", {17'd0, fg_cnt}, expFg);
            checkOutput("idle_rd_busy", {30'd0, res_rd, busy}, 32'd0);
            repeat (5) @(negedge clk);
            checkOutput("done_held", {31'd0, done}, 32'd1);
            checkOutput("max_val_held", {24'd0, max_val}, expMax);
            checkOutput("fg_cnt_held", {17'd0, fg_cnt}, expFg);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_state", {31'd0, anyOutput()}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // All-zero map, threshold 1.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'd0;
        applyStimulus(8'd1, 0, 0);

        // Single pixel at address 17 equal to the threshold.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'd0;
        mem[17] = 8'd5;
        applyStimulus(8'd5, 0, 0);
        checkOutput("word1_seen_pixel17", {18'd0, max_addr}, 32'd17);

        // Two equal peaks on a constant background.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'd3;
        mem[100] = 8'd9;
        mem[200] = 8'd9;
        applyStimulus(8'd4, 0, 0);

        // Random map, threshold 0, reset part way through.
        for (int i = 0; i < NPIX; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        applyStimulus(8'd0, 0, 5000);

        // Random map and threshold after reset, with a stray start mid-scan.
        for (int i = 0; i < NPIX; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        applyStimulus(8'($urandom_range(1, 200)), 300, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dt_thresh.md
DT_THRESH -- requirements
Module: dt_thresh

Interface
REQ-001 SHALL have parameter IMG_PIX, default 16384, meaning pixel count of the 128x128 distance map.
REQ-002 SHALL have parameter WORD_PIX, default 16, meaning pixels packed per output word.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port: clk  input  1  system clock, rising edge.
REQ-005 SHALL have port: reset  input  1  async active-high reset.
REQ-006 SHALL have port: start  input  1  single-cycle request to begin a scan.
REQ-007 SHALL have port: thr  input  8  threshold, latched at start.
REQ-008 SHALL have port: res_rd  output  1  distance-map read strobe.
REQ-009 SHALL have port: res_addr  output  14  distance-map pixel address, row-major.
REQ-010 SHALL have port: res_di  input  8  distance-map read data.
REQ-011 SHALL have port: out_wr  output  1  packed-mask write strobe.
REQ-012 SHALL have port: out_addr  output  10  packed-mask word address.
REQ-013 SHALL have port: out_do  output  16  packed-mask write data.
REQ-014 SHALL have port: busy  output  1  scan in progress.
REQ-015 SHALL have port: done  output  1  results valid; level.
REQ-016 SHALL have port: max_val  output  8  largest distance in map.
REQ-017 SHALL have port: max_addr  output  14  lowest address holding max_val.
REQ-018 SHALL have port: fg_cnt  output  15  count of nonzero pixels (0..16384).

Function
REQ-019 SHALL implement states IDLE, READ, DRAIN, DONE.
REQ-020 SHALL leave IDLE or DONE for READ when start=1 is sampled; SHALL then clear done, max_val, max_addr, fg_cnt, pack register and latch thr.
REQ-021 SHALL ignore start while busy=1.
REQ-022 SHALL in READ drive res_rd=1 and res_addr 0,1,...,16383 on consecutive cycles, one address per cycle, no gaps.
REQ-023 SHALL go READ->DRAIN after issuing address 16383; DRAIN->DONE after the final out_wr cycle.
REQ-024 SHALL treat res_di as valid in the cycle after the cycle its address was driven with res_rd=1 (one-cycle read latency).
REQ-025 SHALL compute mask bit = 1 iff res_di >= latched thr (unsigned); thr=0 yields all ones.
REQ-026 SHALL place pixel a in word a[13:4], bit 15-a[3:0] (leftmost pixel in MSB).
REQ-027 SHALL, when pixel with a[3:0]=15 is captured, assert out_wr=1 for exactly the next cycle with out_addr=a[13:4] and the complete word on out_do; exactly 1024 writes per scan, ascending addresses.
REQ-028 SHALL update max_val/max_addr only on strictly greater value (ties keep lower address); all-zero map gives max_val=0, max_addr=0.
REQ-029 SHALL increment fg_cnt per nonzero pixel; width 15 bits, no wrap possible.
REQ-030 SHALL hold busy=1 from the cycle after start is accepted through the last out_wr cycle.
REQ-031 SHALL assert done=1 from the cycle after the last out_wr until the next accepted start; max_val, max_addr, fg_cnt stable while done=1.
REQ-032 SHALL, with start sampled at edge E0, drive read addresses in cycles 1..16384, last out_wr in cycle 16386, done=1 from cycle 16387.
REQ-033 SHALL keep res_rd=0 and out_wr=0 outside READ/DRAIN activity as defined above.

Reset
REQ-034 SHALL on reset=1, at any time including mid-scan, force state IDLE and all outputs to 0 (res_rd, res_addr, out_wr, out_addr, out_do, busy, done, max_val, max_addr, fg_cnt).
REQ-035 SHALL issue no writes after reset until a new start; a following start SHALL produce a complete correct scan.

Verification
REQ-036 SHALL pass: all-zero map, thr=1 -> 1024 writes of 0x0000, max_val=0, max_addr=0, fg_cnt=0, done at cycle 16387.
REQ-037 SHALL pass: only pixel 17 = 5, thr=5 -> word 1 = 0x4000, all others 0x0000, max_val=5, max_addr=17, fg_cnt=1.
REQ-038 SHALL pass: pixels 100 and 200 = 9, others 3, thr=4 -> max_val=9, max_addr=100, fg_cnt=16384, word 6 = 0x0800, word 12 = 0x0080.
REQ-039 SHALL pass: any map, thr=0 -> all 1024 words 0xFFFF.
REQ-040 SHALL pass: reset pulsed at cycle 5000 -> all outputs 0 next cycle, no out_wr; new start -> full correct scan.
REQ-041 SHALL pass: start re-asserted at cycle 300 of a scan -> ignored, write sequence and results unchanged.
